mac_job_scheduler: RTL and testbench
====================================

MAC_JOB_SCHEDULER -- requirements
Module: mac_job_scheduler

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter N_REQ, default 2, number of requesters sharing the MAC engine (2..8).
REQ-003 Parameter LEN_W, default 16, width of beat-count fields.
REQ-004 Parameter TMO_W, default 16, width of no-progress watchdog counter.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 clear_i  in  1  synchronous abort/clear.
REQ-008 req_valid_i  in  N_REQ  job request per requester, held until accepted.
REQ-009 req_in_len_i  in  N_REQ x LEN_W  input beats to stream into engine.
REQ-010 req_out_len_i  in  N_REQ x LEN_W  output beats to drain from engine.
REQ-011 req_ready_o  out  N_REQ  one-hot accept pulse.
REQ-012 load_start_o / eng_start_o  out  1 each  one-cycle start pulses to streamer / engine.
REQ-013 load_len_o / drain_len_o  out  LEN_W each  latched lengths of current job.
REQ-014 in_beat_i / out_beat_i  in  1 each  one input / output stream handshake (valid&ready) this cycle.
REQ-015 eng_done_i  in  1  engine completion pulse.
REQ-016 done_evt_o  out  N_REQ  one-cycle completion event to owning requester.
REQ-017 busy_o  out  1; owner_o  out  $clog2(N_REQ); err_o  out  1 sticky watchdog error.

Function
REQ-018 FSM states IDLE, LOAD, COMPUTE, DRAIN, DONE.
REQ-019 IDLE: if any req_valid_i, grant round-robin starting at (last grant+1) mod N_REQ; req_ready_o[g]=1 that cycle; latch g and both lengths; last grant updated.
REQ-020 IDLE exit: in_len!=0 -> LOAD; else -> COMPUTE.
REQ-021 LOAD: load_start_o=1 on first LOAD cycle only; count in_beat_i; on beat making count==in_len -> COMPUTE.
REQ-022 COMPUTE: eng_start_o=1 on first COMPUTE cycle only; on eng_done_i -> DRAIN if out_len!=0, else DONE; eng_done_i on first cycle accepted.
REQ-023 DRAIN: count out_beat_i; on beat making count==out_len -> DONE.
REQ-024 DONE: done_evt_o[owner]=1 for exactly one cycle; -> IDLE; no grant issued in DONE.
REQ-025 Minimum job (both lengths 0, eng_done_i in first COMPUTE cycle): accept T, COMPUTE T+1, DONE T+2, next grant earliest T+3.
REQ-026 Beats outside their state and eng_done_i outside COMPUTE SHALL be ignored; counters never exceed latched length.
REQ-027 busy_o=1 in every state except IDLE; owner_o valid while busy_o.
REQ-028 Watchdog: in LOAD/COMPUTE/DRAIN counts cycles without in_beat_i/eng_done_i/out_beat_i respectively; reset on progress; at all-ones -> err_o=1, FSM -> IDLE, no done_evt_o.
REQ-029 err_o sticky until clear_i or reset; scheduling continues while err_o=1.
REQ-030 clear_i (any state, priority over all events): next cycle IDLE, counters 0, err_o 0, round-robin pointer to N_REQ-1 (so requester 0 first), no pulses that cycle.
REQ-031 Requests deasserted before accept are dropped without side effect.

Reset
REQ-032 During rst_i: state IDLE, all outputs 0, counters 0, lengths 0, round-robin pointer N_REQ-1.
REQ-033 Reset mid-job SHALL abort immediately without done_evt_o.

Structure
REQ-034 State enum and scheduler ctrl/flags typedefs SHALL live in mac_package.
REQ-035 Round-robin grant logic SHALL be a sub-module mac_rr_arbiter (N_REQ parameter, req in, one-hot grant out, pointer update enable).

Verification
REQ-036 Req0 in=4, out=2, beats every cycle, eng_done_i 3 cycles after eng_start_o -> single load_start_o, single eng_start_o, done_evt_o[0] once, busy_o low after DONE.
REQ-037 Req0 and req1 asserted continuously, all lengths 0 -> grants alternate 0,1,0,1, grant spacing 3 cycles.
REQ-038 in=0, out=0, eng_done_i first COMPUTE cycle -> LOAD and DRAIN skipped, done_evt_o at T+2.
REQ-039 TMO_W=4, no in_beat_i in LOAD -> err_o rises after 15 idle cycles, FSM IDLE, no done_evt_o, next request still granted.
REQ-040 clear_i asserted in DRAIN with 1 of 3 beats done -> IDLE next cycle, err_o 0, no done_evt_o, next grant to requester 0.
REQ-041 Stray out_beat_i during LOAD and eng_done_i during DRAIN -> counts unaffected, job completes normally.

Source files
------------

// File: rtl/mac_package.sv
// Shared types for the MAC job scheduler: FSM state encoding and per-cycle control flags.
package mac_package;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic load_start;
    logic eng_start;
    logic done;
    logic progress;
    logic timeout;
  } sched_flags_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter: searches from (last grant + 1) mod N_REQ, returns one-hot grant and index.
module mac_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o
);

  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  logic [IW-1:0] ptr;
  logic [IW:0]   idx;
  logic          found;

  // One extra bit on idx so ptr+i never wraps before the explicit mod-N fold.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && req_i[idx[IW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[idx[IW-1:0]]     = 1'b1;
        gnt_idx_o              = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 ptr <= LAST;
    else if (clear_i)          ptr <= LAST;
    else if (upd_i && |req_i)  ptr <= gnt_idx_o;
  end

endmodule

// File: rtl/mac_job_scheduler.sv
// Shares one MAC engine among N_REQ requesters: grant, stream in, compute, drain, signal done.
module mac_job_scheduler
  import mac_package::*;
#(
  parameter  int N_REQ = 2,
  parameter  int LEN_W = 16,
  parameter  int TMO_W = 16,
  localparam int OW    = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0][LEN_W-1:0] req_in_len_i,
  input  logic [N_REQ-1:0][LEN_W-1:0] req_out_len_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        load_start_o,
  output logic                        eng_start_o,
  output logic [LEN_W-1:0]            load_len_o,
  output logic [LEN_W-1:0]            drain_len_o,
  input  logic                        in_beat_i,
  input  logic                        out_beat_i,
  input  logic                        eng_done_i,
  output logic [N_REQ-1:0]            done_evt_o,
  output logic                        busy_o,
  output logic [OW-1:0]               owner_o,
  output logic                        err_o
);

  // Trip one short of all-ones so err_o rises exactly when the count would reach all-ones.
  localparam logic [TMO_W-1:0] WD_TRIP = {{(TMO_W-1){1'b1}}, 1'b0};

  sched_state_t       state, nxt;
  sched_flags_t       fl;
  logic [OW-1:0]      owner;
  logic [LEN_W-1:0]   in_len, out_len, cnt, cnt_nx;
  logic [TMO_W-1:0]   wdog;
  logic               entry, err, accept, busy_st;
  logic [N_REQ-1:0]   gnt;
  logic [OW-1:0]      gnt_idx;

  mac_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .req_i     (req_valid_i),
    .upd_i     (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign cnt_nx  = cnt + LEN_W'(1);
  assign busy_st = (state == ST_LOAD) || (state == ST_COMPUTE) || (state == ST_DRAIN);

  always_comb begin
    nxt    = state;
    fl     = '0;
    accept = (state == ST_IDLE) && (|req_valid_i) && !clear_i && !rst_i;
    case (state)
      ST_IDLE:    if (accept) nxt = (req_in_len_i[gnt_idx] != '0) ? ST_LOAD : ST_COMPUTE;
      ST_LOAD: begin
        fl.load_start = entry;
        fl.progress   = in_beat_i;
        if (in_beat_i && cnt_nx == in_len) nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        fl.eng_start = entry;
        fl.progress  = eng_done_i;
        if (eng_done_i) nxt = (out_len != '0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        fl.progress = out_beat_i;
        if (out_beat_i && cnt_nx == out_len) nxt = ST_DONE;
      end
      ST_DONE: begin
        fl.done = 1'b1;
        nxt     = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    fl.timeout = busy_st && !fl.progress && (wdog == WD_TRIP);
    if (fl.timeout) nxt = ST_IDLE;
    if (clear_i) begin
      nxt = ST_IDLE;
      fl  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      owner   <= '0;
      in_len  <= '0;
      out_len <= '0;
      cnt     <= '0;
      wdog    <= '0;
      entry   <= 1'b0;
      err     <= 1'b0;
    end else if (clear_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wdog  <= '0;
      entry <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      entry <= (nxt != state);
      if (accept) begin
        owner   <= gnt_idx;
        in_len  <= req_in_len_i[gnt_idx];
        out_len <= req_out_len_i[gnt_idx];
      end
      if (nxt != state) begin
        cnt  <= '0;
        wdog <= '0;
      end else begin
        if ((state == ST_LOAD && in_beat_i) || (state == ST_DRAIN && out_beat_i)) cnt <= cnt_nx;
        if (fl.progress || !busy_st) wdog <= '0;
        else                         wdog <= wdog + TMO_W'(1);
      end
      if (fl.timeout) err <= 1'b1;
    end
  end

  always_comb begin
    done_evt_o = '0;
    if (fl.done) done_evt_o[owner] = 1'b1;
  end

  assign req_ready_o  = accept ? gnt : '0;
  assign load_start_o = fl.load_start;
  assign eng_start_o  = fl.eng_start;
  assign load_len_o   = in_len;
  assign drain_len_o  = out_len;
  assign busy_o       = (state != ST_IDLE);
  assign owner_o      = owner;
  assign err_o        = err;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Job-level bench for mac_job_scheduler: directed scenarios plus random jobs with stray events.
module tb_mac_job_scheduler;

  localparam int N = 3;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst, clear;
  logic [N-1:0]      req_valid;
  logic [N-1:0][LW-1:0] req_in_len, req_out_len;
  logic [N-1:0]      req_ready;
  logic              load_start, eng_start;
  logic [LW-1:0]     load_len, drain_len;
  logic              in_beat, out_beat, eng_done;
  logic [N-1:0]      done_evt;
  logic              busy;
  logic [1:0]        owner;
  logic              err;

  int ncmp = 0;
  int nfail = 0;
  int last = N - 1;
  bit err_exp = 1'b0;
  int in_l[N];
  int out_l[N];

  always #5 clk = ~clk;

  mac_job_scheduler #(.N_REQ(N), .LEN_W(LW), .TMO_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_in_len_i(req_in_len), .req_out_len_i(req_out_len),
    .req_ready_o(req_ready), .load_start_o(load_start), .eng_start_o(eng_start),
    .load_len_o(load_len), .drain_len_o(drain_len),
    .in_beat_i(in_beat), .out_beat_i(out_beat), .eng_done_i(eng_done),
    .done_evt_o(done_evt), .busy_o(busy), .owner_o(owner), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Round-robin model: first requester after the last grant, cyclically.
  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int g);
    return 32'(1) << g;
  endfunction

  task automatic set_lens();
    for (int r = 0; r < N; r++) begin
      req_in_len[r]  = LW'(in_l[r]);
      req_out_len[r] = LW'(out_l[r]);
    end
  endtask

  task automatic chk_job(input int g);
    chk("ready_busy", req_ready, 0);
    chk("busy", busy, 1);
    chk("owner", owner, g);
    chk("load_len", load_len, in_l[g]);
    chk("drain_len", drain_len, out_l[g]);
    chk("err", err, err_exp);
  endtask

  task automatic rnd_strays();
    in_beat  = 1'($urandom_range(0, 1));
    out_beat = 1'($urandom_range(0, 1));
    eng_done = 1'($urandom_range(0, 1));
  endtask

  // One complete job; beats come with probability pct, engine finishes after dly cycles (dly<0: random).
  task automatic run_job(input logic [N-1:0] mask, input int pct, input int dly);
    int g, nb, gap, d;
    bit first;
    g = exp_grant(mask);
    set_lens();
    req_valid = mask; clear = 0; in_beat = 0; out_beat = 0; eng_done = 0;
    @(negedge clk);
    chk("grant", req_ready, onehot(g));
    chk("busy_idle", busy, 0);
    adv();
    last = g;
    req_valid = mask & ~N'(onehot(g));
    if (in_l[g] != 0) begin
      nb = 0; gap = 0; first = 1;
      while (nb < in_l[g]) begin
        rnd_strays();
        in_beat = ($urandom_range(0, 99) < pct) || gap >= 8;
        @(negedge clk);
        chk_job(g);
        chk("load_start", load_start, first);
        chk("eng_start_load", eng_start, 0);
        chk("done_load", done_evt, 0);
        if (in_beat) begin nb++; gap = 0; end else gap++;
        first = 0;
        adv();
      end
    end
    d = (dly < 0) ? $urandom_range(0, 4) : dly;
    for (int k = 0; k <= d; k++) begin
      rnd_strays();
      eng_done = (k == d);
      @(negedge clk);
      chk_job(g);
      chk("load_start_cmp", load_start, 0);
      chk("eng_start", eng_start, k == 0);
      chk("done_cmp", done_evt, 0);
      adv();
    end
    if (out_l[g] != 0) begin
      nb = 0; gap = 0;
      while (nb < out_l[g]) begin
        rnd_strays();
        out_beat = ($urandom_range(0, 99) < pct) || gap >= 8;
        @(negedge clk);
        chk_job(g);
        chk("eng_start_drn", eng_start, 0);
        chk("done_drn", done_evt, 0);
        if (out_beat) begin nb++; gap = 0; end else gap++;
        adv();
      end
    end
    rnd_strays();
    req_valid = '0;
    @(negedge clk);
    chk("done_evt", done_evt, onehot(g));
    chk("busy_done", busy, 1);
    chk("ready_done", req_ready, 0);
    adv();
    in_beat = 0; out_beat = 0; eng_done = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done_evt, 0);
    chk("idle_err", err, err_exp);
    adv();
  endtask

  initial begin
    int g;
    rst = 1; clear = 0; req_valid = '1; in_beat = 1; out_beat = 1; eng_done = 1;
    for (int r = 0; r < N; r++) begin in_l[r] = 0; out_l[r] = 0; end
    set_lens();
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_lens", {load_len, drain_len}, 0);
    chk("rst_pulses", {load_start, eng_start, done_evt}, 0);
    req_valid = '0; in_beat = 0; out_beat = 0;
    adv();
    rst = 0;
    adv();

    // Two requesters held continuously with empty jobs: grants alternate every 3 cycles.
    req_valid = 3'b011; eng_done = 1;
    g = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        g = exp_grant(3'b011);
        chk("alt_order", g, (c / 3) % 2);
        chk("alt_grant", req_ready, onehot(g));
        last = g;
      end else chk("alt_nogrant", req_ready, 0);
      chk("alt_estart", eng_start, c % 3 == 1);
      chk("alt_done", done_evt, (c % 3 == 2) ? onehot(g) : 0);
      chk("alt_busy", busy, c % 3 != 0);
      adv();
      if (c == 11) req_valid = '0;
    end
    eng_done = 0;
    adv();

    in_l[0] = 4; out_l[0] = 2;
    run_job(3'b001, 100, 3);
    in_l[1] = 0; out_l[1] = 0;
    run_job(3'b010, 50, 0);

    for (int j = 0; j < 20; j++) begin
      for (int r = 0; r < N; r++) begin
        in_l[r] = $urandom_range(0, 4); out_l[r] = $urandom_range(0, 4);
      end
      run_job(N'($urandom_range(1, 7)), 60, -1);
    end

    // Watchdog: LOAD with no beats trips after 15 cycles, job aborted silently.
    in_l[1] = 3; out_l[1] = 1; set_lens();
    req_valid = 3'b010;
    @(negedge clk);
    chk("tmo_grant", req_ready, 3'b010);
    adv();
    last = 1; req_valid = '0;
    for (int k = 0; k < 15; k++) begin
      out_beat = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("tmo_busy", busy, 1);
      chk("tmo_err_low", err, 0);
      chk("tmo_lstart", load_start, k == 0);
      adv();
    end
    out_beat = 0;
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_err", err, 1);
    chk("tmo_nodone", done_evt, 0);
    adv();
    err_exp = 1;
    in_l[2] = 2; out_l[2] = 2;
    run_job(3'b100, 70, -1);

    // clear_i in DRAIN after 1 of 3 beats.
    in_l[1] = 0; out_l[1] = 3; set_lens();
    req_valid = 3'b010;
    @(negedge clk);
    chk("clr_grant", req_ready, 3'b010);
    adv();
    req_valid = '0; eng_done = 1;
    @(negedge clk);
    chk("clr_estart", eng_start, 1);
    adv();
    eng_done = 0; out_beat = 1;
    @(negedge clk);
    chk("clr_drain", busy, 1);
    adv();
    out_beat = 0; clear = 1; req_valid = 3'b101; eng_done = 1;
    @(negedge clk);
    chk("clr_noready", req_ready, 0);
    chk("clr_nopulse", {load_start, eng_start, done_evt}, 0);
    adv();
    clear = 0; eng_done = 0; req_valid = '0;
    last = N - 1; err_exp = 0;
    @(negedge clk);
    chk("clr_idle", busy, 0);
    chk("clr_err", err, 0);
    chk("clr_nodone", done_evt, 0);
    adv();
    in_l[0] = 1; out_l[0] = 1;
    run_job(3'b101, 80, -1);

    // Asynchronous reset mid-job.
    in_l[0] = 5; set_lens();
    req_valid = 3'b001;
    adv();
    last = 0; req_valid = '0; in_beat = 1;
    adv();
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done_evt, 0);
    chk("arst_len", load_len, 0);
    adv();
    rst = 0; in_beat = 0; last = N - 1;
    adv();
    in_l[1] = 2; out_l[1] = 0;
    run_job(3'b110, 60, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
